// File: rtl/le_regiao_cursor_if.sv
// le_regiao_cursor_if: scan request, framebuffer read port and pixel stream of the cursor-region reader.
// master is the environment side (requester, RAM, consumer); slave is the reader itself.
interface le_regiao_cursor_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
);
    logic              start;
    logic [10:0]       x_cursor;
    logic [10:0]       y_cursor;
    logic [6:0]        SIZE;
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [10:0]       out_x;
    logic [10:0]       out_y;
    logic              out_last;

    modport master (
        output start, x_cursor, y_cursor, SIZE, mem_data, out_ready,
        input  busy, done, mem_rd, mem_addr, out_valid, out_data, out_x, out_y, out_last
    );
    modport slave (
        input  start, x_cursor, y_cursor, SIZE, mem_data, out_ready,
        output busy, done, mem_rd, mem_addr, out_valid, out_data, out_x, out_y, out_last
    );
endinterface

// File: rtl/le_regiao_cursor.sv
// le_regiao_cursor: reads the SIZE x SIZE framebuffer square under the cursor and streams it
// in raster order with coordinates; off-screen pixels take a slot and are emitted as zero.
module le_regiao_cursor #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12,
    parameter int RD_LAT = 2
) (
    input logic               clock,
    input logic               reset,
    le_regiao_cursor_if.slave bus
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
    typedef struct packed {
        logic        valid;
        logic [10:0] x;
        logic [10:0] y;
        logic        last;
        logic        off;
    } tag_t;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [10:0]       x;
        logic [10:0]       y;
        logic              last;
    } ent_t;

    state_t        state_q, state_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [10:0]   x0_q, x0_d, y0_q, y0_d;
    logic [6:0]    s_q, s_d;
    logic [11:0]   cx_q, cx_d, cy_q, cy_d, x_end, y_end;
    tag_t          pipe_q [RD_LAT];
    tag_t          pipe_d [RD_LAT];
    tag_t          tail;
    ent_t          fifo_q [DEPTH];
    ent_t          head, push_ent;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d, inflight;
    logic          credit, issue, off, last_pix, push, pop;

    // Bounds in 12 bits so a square hanging past x=2047 does not wrap back on-screen.
    assign x_end    = {1'b0, x0_q} + {5'b0, s_q} - 12'd1;
    assign y_end    = {1'b0, y0_q} + {5'b0, s_q} - 12'd1;
    assign off      = cx_q >= 12'(H_RES) || cy_q >= 12'(V_RES);
    assign last_pix = cx_q == x_end && cy_q == y_end;
    assign credit   = int'(cnt_q) + int'(inflight) < DEPTH;
    assign issue    = state_q == ISSUE && credit;

    assign bus.mem_rd   = issue && !off;
    assign bus.mem_addr = bus.mem_rd ? ADDR_W'(cy_q) * ADDR_W'(H_RES) + ADDR_W'(cx_q) : '0;

    assign tail     = pipe_q[RD_LAT-1];
    assign push     = tail.valid;
    assign pop      = bus.out_valid && bus.out_ready;
    assign push_ent = '{tail.off ? {DATA_W{1'b0}} : bus.mem_data, tail.x, tail.y, tail.last};
    assign head     = fifo_q[rd_q];

    assign bus.out_valid = cnt_q != '0;
    assign bus.out_data  = bus.out_valid ? head.data : '0;
    assign bus.out_x     = bus.out_valid ? head.x : '0;
    assign bus.out_y     = bus.out_valid ? head.y : '0;
    assign bus.out_last  = bus.out_valid && head.last;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pipe_q[i].valid);
        pipe_d[0] = '{issue, cx_q[10:0], cy_q[10:0], last_pix, off};
        for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
        wr_d  = push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d  = pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        s_d     = s_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        case (state_q)
            IDLE: if (bus.start) begin
                if (|bus.SIZE) begin
                    x0_d    = bus.x_cursor;
                    y0_d    = bus.y_cursor;
                    s_d     = bus.SIZE;
                    cx_d    = {1'b0, bus.x_cursor};
                    cy_d    = {1'b0, bus.y_cursor};
                    state_d = ISSUE;
                end else begin
                    state_d = FIN;
                end
            end
            ISSUE: if (credit) begin
                cx_d    = cx_q == x_end ? {1'b0, x0_q} : cx_q + 12'd1;
                cy_d    = cx_q == x_end ? cy_q + 12'd1 : cy_q;
                state_d = last_pix ? DRAIN : ISSUE;
            end
            // The last pixel is the youngest entry, so its handshake means pipeline and FIFO are empty.
            DRAIN: state_d = pop && bus.out_last ? FIN : DRAIN;
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == FIN;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x0_q    <= '0;
            y0_q    <= '0;
            s_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            pipe_q  <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            s_q     <= s_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            pipe_q  <= pipe_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_q] <= push_ent;
    end
endmodule

// File: tb/tb_le_regiao_cursor.sv
// tb_le_regiao_cursor: scoreboard bench; expected pixels come from a raster-walk model of the square
// and a synthetic framebuffer, compared by an independent stream monitor.
module tb_le_regiao_cursor;
    localparam int H_RES = 640, V_RES = 480, ADDR_W = 19, DATA_W = 12, RD_LAT = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    le_regiao_cursor_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    le_regiao_cursor #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT))
        dut (.clock(clk), .reset(rst_n), .bus(bus));

    typedef struct { int x; int y; int d; bit last; } pix_t;
    pix_t sb[$];
    pix_t mon_e;
    int n_chk = 0, n_pass = 0;
    int rd_cnt = 0, hs_cnt = 0, done_cnt = 0, vld_cnt = 0;
    longint last_addr = 0;
    int rdy_mode = 0;

    function automatic int pix(input int a);
        return (a * 37 + (a >> 7) + 5) & 12'hFFF;
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Framebuffer with fixed latency; non-read cycles return garbage so zeroing is observable.
    logic [DATA_W-1:0] rdp [RD_LAT];
    always @(posedge clk) begin
        rdp[0] <= bus.mem_rd ? DATA_W'(pix(int'(bus.mem_addr))) : 12'hABC;
        for (int i = 1; i < RD_LAT; i++) rdp[i] <= rdp[i-1];
    end
    assign bus.mem_data = rdp[RD_LAT-1];

    always @(posedge clk) begin
        #1;
        bus.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
    end

    bit held = 0;
    logic [34:0] held_v;
    always @(negedge clk) begin
        if (!rst_n) held = 0;
        else begin
            if (held) begin
                check(bus.out_valid, "hold_valid", bus.out_valid, 1);
                check({bus.out_data, bus.out_x, bus.out_y, bus.out_last} == held_v, "hold_stable",
                      {bus.out_data, bus.out_x, bus.out_y, bus.out_last}, held_v);
            end
            held = 0;
            if (bus.mem_rd) begin
                rd_cnt++;
                last_addr = bus.mem_addr;
            end
            if (bus.out_valid) vld_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                if (sb.size() == 0) check(0, "unexpected_out", bus.out_x, -1);
                else begin
                    mon_e = sb.pop_front();
                    check(int'(bus.out_x) == mon_e.x, "out_x", bus.out_x, mon_e.x);
                    check(int'(bus.out_y) == mon_e.y, "out_y", bus.out_y, mon_e.y);
                    check(int'(bus.out_data) == mon_e.d, "out_data", bus.out_data, mon_e.d);
                    check(bus.out_last == mon_e.last, "out_last", bus.out_last, mon_e.last);
                end
            end else if (bus.out_valid) begin
                held = 1;
                held_v = {bus.out_data, bus.out_x, bus.out_y, bus.out_last};
            end
            if (bus.done) begin
                done_cnt++;
                check(sb.size() == 0, "done_after_last", sb.size(), 0);
            end
        end
    end

    task automatic push_exp(input int x, input int y, input int s);
        for (int j = 0; j < s; j++) begin
            for (int i = 0; i < s; i++) begin
                pix_t e;
                int px, py;
                px = x + i;
                py = y + j;
                e.x = px % 2048;
                e.y = py % 2048;
                e.d = (px < H_RES && py < V_RES) ? pix(py * H_RES + px) : 0;
                e.last = (i == s - 1 && j == s - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic set_req(input int x, input int y, input int s);
        bus.x_cursor = 11'(x);
        bus.y_cursor = 11'(y);
        bus.SIZE = 7'(s);
        bus.start = 1'b1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (bus.done) break;
            n++;
        end
        check(n < 3000, "done_timeout", n, 3000);
        tick();
    endtask

    task automatic run_scan(input int x, input int y, input int s, input bit second);
        push_exp(x, y, s);
        set_req(x, y, s);
        tick();
        bus.start = 1'b0;
        if (second) begin
            repeat (2) tick();
            set_req(300, 7, 5);
            tick();
            bus.start = 1'b0;
        end
        wait_done();
    endtask

    task automatic reset_checks(input string tag);
        check(bus.busy == 0, {tag, "_busy"}, bus.busy, 0);
        check(bus.done == 0, {tag, "_done"}, bus.done, 0);
        check(bus.mem_rd == 0, {tag, "_mem_rd"}, bus.mem_rd, 0);
        check(bus.mem_addr == 0, {tag, "_mem_addr"}, bus.mem_addr, 0);
        check(bus.out_valid == 0, {tag, "_out_valid"}, bus.out_valid, 0);
        check(bus.out_data == 0, {tag, "_out_data"}, bus.out_data, 0);
        check(bus.out_x == 0, {tag, "_out_x"}, bus.out_x, 0);
        check(bus.out_y == 0, {tag, "_out_y"}, bus.out_y, 0);
        check(bus.out_last == 0, {tag, "_out_last"}, bus.out_last, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t1_addr[4] = '{12810, 12811, 13450, 13451};
        int r0, v0, h0, d0;
        bus.start = 1'b0;
        bus.x_cursor = '0;
        bus.y_cursor = '0;
        bus.SIZE = '0;
        repeat (3) tick();
        @(negedge clk);
        reset_checks("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // Cycle-exact first scan
        push_exp(10, 20, 2);
        set_req(10, 20, 2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check(bus.mem_rd == (c >= 1 && c <= 4), $sformatf("t1_rd_c%0d", c), bus.mem_rd, c >= 1 && c <= 4);
            if (c >= 1 && c <= 4)
                check(int'(bus.mem_addr) == t1_addr[c-1], $sformatf("t1_addr_c%0d", c), bus.mem_addr, t1_addr[c-1]);
            check(bus.out_valid == (c >= 4 && c <= 7), $sformatf("t1_valid_c%0d", c), bus.out_valid, c >= 4 && c <= 7);
            check(bus.out_last == (c == 7), $sformatf("t1_last_c%0d", c), bus.out_last, c == 7);
            check(bus.done == (c == 8), $sformatf("t1_done_c%0d", c), bus.done, c == 8);
            check(bus.busy == (c >= 1 && c <= 8), $sformatf("t1_busy_c%0d", c), bus.busy, c >= 1 && c <= 8);
            tick();
            if (c == 0) bus.start = 1'b0;
        end

        // Bottom-right corner clipping
        r0 = rd_cnt;
        run_scan(639, 479, 2, 0);
        check(rd_cnt - r0 == 1, "corner_reads", rd_cnt - r0, 1);
        check(last_addr == 307199, "corner_addr", last_addr, 307199);

        // Backpressure: credit limits reads, then full delivery
        rdy_mode = 1;
        r0 = rd_cnt;
        h0 = hs_cnt;
        push_exp(50, 60, 3);
        set_req(50, 60, 3);
        tick();
        bus.start = 1'b0;
        repeat (20) tick();
        check(rd_cnt - r0 <= 4 && rd_cnt - r0 > 0, "stall_reads", rd_cnt - r0, 4);
        check(bus.out_valid == 1, "stall_valid", bus.out_valid, 1);
        rdy_mode = 0;
        wait_done();
        check(hs_cnt - h0 == 9, "stall_count", hs_cnt - h0, 9);
        check(rd_cnt - r0 == 9, "stall_reads_total", rd_cnt - r0, 9);

        // Zero-size request
        r0 = rd_cnt;
        v0 = vld_cnt;
        set_req(5, 5, 0);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        check(bus.busy == 1, "s0_busy", bus.busy, 1);
        check(bus.done == 1, "s0_done", bus.done, 1);
        tick();
        @(negedge clk);
        check(bus.busy == 0, "s0_idle", bus.busy, 0);
        tick();
        check(rd_cnt - r0 == 0, "s0_reads", rd_cnt - r0, 0);
        check(vld_cnt - v0 == 0, "s0_valid", vld_cnt - v0, 0);

        // Start during a scan is ignored
        h0 = hs_cnt;
        run_scan(100, 50, 3, 1);
        check(hs_cnt - h0 == 9, "ignored_start_count", hs_cnt - h0, 9);

        // Reset mid-scan aborts without done
        push_exp(200, 100, 4);
        set_req(200, 100, 4);
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        reset_checks("mid");
        repeat (3) tick();
        check(done_cnt == d0, "mid_no_done", done_cnt - d0, 0);
        sb.delete();
        rst_n = 1'b1;
        tick();
        h0 = hs_cnt;
        run_scan(200, 100, 4, 0);
        check(hs_cnt - h0 == 16, "post_reset_count", hs_cnt - h0, 16);

        // Randomised scans with random backpressure
        rdy_mode = 2;
        for (int k = 0; k < 25; k++) begin
            int x, y, s;
            x = (k % 4 == 0) ? int'($urandom_range(1900, 2047)) : int'($urandom_range(0, 700));
            y = int'($urandom_range(0, 520));
            s = int'($urandom_range(0, 8));
            d0 = done_cnt;
            run_scan(x, y, s, 0);
            check(done_cnt - d0 == 1, "rand_done", done_cnt - d0, 1);
        end
        rdy_mode = 0;
        tick();
        check(sb.size() == 0, "sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/le_regiao_cursor.md
Name: le_regiao_cursor

Overview:
- Framebuffer reader, the counterpart of the cursor painter: on a start pulse it walks the same SIZE x SIZE square anchored at (x_cursor, y_cursor) in raster order.
- For each pixel it issues a read to the framebuffer RAM, which has a fixed read latency.
- It streams the returned pixels with their coordinates over a valid/ready interface.
- Use case: save the background under the cursor before painting, so it can be restored later.

Parameters:
- H_RES, 640: screen width in pixels; also the address stride.
- V_RES, 480: screen height in pixels.
- ADDR_W, 19: framebuffer address width.
- DATA_W, 12: pixel width.
- RD_LAT, 2: fixed RAM read latency in cycles, minimum 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state is cleared while reset==0.
- start  in  1  one-cycle request to begin a scan; ignored while busy.
- x_cursor  in  11  top-left x of the square; sampled on an accepted start.
- y_cursor  in  11  top-left y of the square; sampled on an accepted start.
- SIZE  in  7  side length of the square; sampled on an accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at scan completion.
- mem_rd  out  1  read strobe to the framebuffer.
- mem_addr  out  ADDR_W  read address, y*H_RES + x.
- mem_data  in  DATA_W  read data; valid RD_LAT cycles after the mem_rd cycle.
- out_valid  out  1  a pixel is available on the output stream.
- out_ready  in  1  consumer accepts the output pixel.
- out_data  out  DATA_W  pixel value.
- out_x  out  11  pixel x coordinate.
- out_y  out  11  pixel y coordinate.
- out_last  out  1  marks the final pixel of the square.

Behaviour:
- Reset values: busy=0, done=0, mem_rd=0, mem_addr=0, out_valid=0, out_data=0, out_x=0, out_y=0, out_last=0.
- Reset also clears the FIFO, the latency pipeline and the counters. An asserted reset mid-scan aborts the scan; no done pulse is produced.

State machine (IDLE, ISSUE, DRAIN, FIN):
- IDLE:
  - start=1 with SIZE>0: latch x0, y0, S; set counters cx=x0, cy=y0; go to ISSUE.
  - start=1 with SIZE=0: go to FIN. No reads and no output are produced.
- ISSUE: one pixel per cycle, only when credit is available.
  - Credit condition: fifo_count + inflight < FIFO_DEPTH, where FIFO_DEPTH = RD_LAT+2.
  - Credit available: advance cx; wrap cx to x0 and increment cy at x0+S-1. The last issued pixel (x0+S-1, y0+S-1) moves the FSM to DRAIN.
  - No credit: the FSM holds and mem_rd=0.
- DRAIN: wait until the pipeline and the FIFO are empty and the last pixel has handshaken, then go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- busy=1 in ISSUE, DRAIN and FIN.
- A start that is not in IDLE is ignored; latched values do not change mid-scan.

Reads and clipping:
- mem_rd and mem_addr are combinational from the state and counters, asserted in the issue cycle. The RAM samples them on that cycle's closing edge.
- Bounds are computed in 12-bit arithmetic (x0+S-1, y0+S-1), so coordinates never wrap.
- A pixel is off-screen when cx>=H_RES or cy>=V_RES. It still takes a pipeline slot and is emitted, in order, with out_data=0. mem_rd stays 0 for it; mem_addr is don't-care.

Latency pipeline and FIFO:
- An RD_LAT-deep shift register carries {valid, x, y, last, offscreen} alongside each read.
- At stage RD_LAT, mem_data (or 0 if off-screen) is pushed into the FIFO in the same cycle it arrives.
- FIFO_DEPTH = RD_LAT+2 entries, first-word fall-through; out_* come from the head entry.
- Pixel order at the output is strictly raster.
- Latency: a start accepted at cycle 0 gives a first read at cycle 1 and a first out_valid at cycle RD_LAT+2.
- Throughput is 1 pixel/cycle while out_ready=1.
- Stream rules:
  - out_valid, once high, stays high and out_* stay stable until the handshake (out_valid & out_ready).
  - A push and a pop in the same cycle are both performed.
  - The FIFO never overflows, because of the credit check.
- done pulses in the cycle after the handshake of the out_last pixel.

Test Plan:
- RD_LAT=2; start with (10,20), SIZE=2; out_ready=1.
  - mem_rd in cycles 1-4 with addr 12810, 12811, 13450, 13451.
  - out_valid in cycles 4-7 with (x,y) (10,20), (11,20), (10,21), (11,21) and the data returned by the RAM.
  - out_last in cycle 7; done in cycle 8.
- Start with (639,479), SIZE=2.
  - Exactly one mem_rd, addr 307199.
  - 4 outputs in raster order; (640,479), (639,480) and (640,480) have out_data=0.
- SIZE=3 with out_ready=0 for 20 cycles.
  - At most 4 mem_rd issued; out_valid held with out_* stable.
- SIZE=3, release out_ready after the 20 cycles above.
  - All 9 pixels delivered in order with no loss or duplication; done only after the 9th handshake.
- Start with SIZE=0.
  - busy high for one cycle, done pulse, no mem_rd, no out_valid.
- Second start pulse during a scan with different x_cursor.
  - Ignored: coordinates and pixel count follow the first request.
- Assert reset mid-scan, then release.
  - All outputs at reset values, no done pulse.
  - A new start then scans correctly from the first pixel.
